// File: rtl/atomrvcore_pkg.sv
// Shared types and constants for the atomrvcore fetch path.
//   XLEN / ILEN    : address and instruction widths
//   fetch_entry_t  : one buffered {pc, instr} pair
//   INSTR_NOP      : canonical addi x0,x0,0 encoding
//   word_align()   : clears the byte offset of an address
package atomrvcore_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/atomrvcore_fifo.sv
// Synchronous FIFO of fetch_entry_t with a single-cycle flush.
//   clk_i    : clock
//   rst_i    : asynchronous reset, active-high; storage and pointers cleared
//   flush_i  : drop all entries this cycle (overrides push and pop)
//   push_i   : write wdata_i at the tail
//   wdata_i  : entry to write
//   pop_i    : remove the head entry (ignored when empty)
//   rdata_o  : head entry, read straight from the storage registers
//   count_o  : number of valid entries
module atomrvcore_fifo
  import atomrvcore_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             wdata_i,
  input  logic                     pop_i,
  output fetch_entry_t             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);

  always_comb begin
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/atomrvcore_prefetch_ifu.sv
// Prefetching instruction fetch unit. Streams sequential ICCM reads ahead of the
// decoder, buffers up to DEPTH {pc, instr} entries and flushes on redirects.
// Optional feature macro: ATOMRV_IFU_PERF_EN adds handshake / redirect counters.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   imem_req_o, imem_addr_o      : ICCM read request (accepted every cycle)
//   imem_rvalid_i, imem_rdata_i  : in-order ICCM read response
//   instr_valid_o, instr_ready_i : decoder handshake on the head entry
//   instr_o, pc_o                : head entry
//   redirect_i, redirect_pc_i    : taken branch/jump target from execute
//   perf_fetch_o, perf_flush_o   : (ATOMRV_IFU_PERF_EN) event counters
module atomrvcore_prefetch_ifu
  import atomrvcore_pkg::*;
#(
  parameter int unsigned            DATAWIDTH = 32,
  parameter int unsigned            DEPTH     = 4,
  parameter logic [DATAWIDTH-1:0]   RESET_PC  = '0,
  parameter int unsigned            PERF_W    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [DATAWIDTH-1:0]  imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [DATAWIDTH-1:0]  imem_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATAWIDTH-1:0]  instr_o,
  output logic [DATAWIDTH-1:0]  pc_o,
  input  logic                  redirect_i,
  input  logic [DATAWIDTH-1:0]  redirect_pc_i
`ifdef ATOMRV_IFU_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_fetch_o,
  output logic [PERF_W-1:0]     perf_flush_o
`endif
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATAWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATAWIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [CW-1:0]        count;
  logic [CW-1:0]        inflight;
  logic [DATAWIDTH-1:0] target;
  logic                 issue, push, handshake;
  fetch_entry_t         push_entry, head;

  assign target    = word_align(redirect_pc_i);
  assign inflight  = count + outstanding_q;
  // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
  assign issue     = !rst_i && !redirect_i && (inflight < DEPTH_C);
  assign handshake = instr_valid_o && instr_ready_i;
  assign push      = imem_rvalid_i && (drop_q == '0) && !redirect_i;

  assign push_entry.pc    = resp_pc_q;
  assign push_entry.instr = imem_rdata_i;

  atomrvcore_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (handshake),
    .rdata_o (head),
    .count_o (count)
  );

  always_comb begin
    outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid_i);

    // On a redirect every read still in flight after this cycle predates the
    // target, so the drop count becomes exactly that number. Reads already
    // marked for dropping are part of outstanding_q and must not be added twice.
    drop_d = drop_q;
    if (redirect_i) begin
      drop_d = outstanding_q - CW'(imem_rvalid_i);
    end else if (imem_rvalid_i && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = target;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + DATAWIDTH'(4);
    end

    resp_pc_d = resp_pc_q;
    if (redirect_i) begin
      resp_pc_d = target;
    end else if (push) begin
      resp_pc_d = resp_pc_q + DATAWIDTH'(4);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  assign imem_req_o    = issue;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (count != '0);
  assign instr_o       = DATAWIDTH'(head.instr);
  assign pc_o          = DATAWIDTH'(head.pc);

`ifdef ATOMRV_IFU_PERF_EN
  logic [PERF_W-1:0] perf_fetch_q, perf_flush_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_q + PERF_W'(handshake);
      perf_flush_q <= perf_flush_q + PERF_W'(redirect_i);
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_atomrvcore_prefetch_ifu.sv
// Bench for atomrvcore_prefetch_ifu: ICCM model with configurable latency, a
// stream-level reference (expected fetch address and expected head pc, both
// restarting at each redirect target) checked every cycle, plus directed cases.
module tb_atomrvcore_prefetch_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef ATOMRV_IFU_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
`endif

  atomrvcore_prefetch_ifu #(
    .DATAWIDTH (32),
    .DEPTH     (4),
    .RESET_PC  (32'h0),
    .PERF_W    (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
`ifdef ATOMRV_IFU_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch),
    .perf_flush_o  (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lat         = 1;
  int req_cnt     = 0;
  int hs_cnt      = 0;

  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] exp_pc    = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ICCM: answers each request in order exactly lat cycles later.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        q_addr.delete();
        q_due.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  // Stream reference: addresses and head pcs run sequentially from the last
  // redirect target (or reset PC); instructions are mem_word(pc).
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_fetch = 32'h0;
        exp_pc    = 32'h0;
      end else begin
        if (redirect) chk("req_in_redirect", 32'(imem_req), 32'h0);
        if (imem_req) begin
          chk("req_addr", imem_addr, exp_fetch);
          q_addr.push_back(imem_addr);
          q_due.push_back(cyc + lat);
          exp_fetch = exp_fetch + 32'd4;
          req_cnt++;
        end
        if (instr_valid) begin
          chk("head_pc", pc, exp_pc);
          chk("head_instr", instr, mem_word(exp_pc));
          if (instr_ready) begin
            exp_pc = exp_pc + 32'd4;
            hs_cnt++;
          end
        end
        if (redirect) begin
          exp_fetch = {redirect_pc[31:2], 2'b00};
          exp_pc    = {redirect_pc[31:2], 2'b00};
        end
      end
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    rst = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first cycle with instr_valid high.
  task automatic wait_valid(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
      else tick();
    end
    if (!found) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  int h0, r0, c_red;

  initial begin
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Straight-line fetch, 1-cycle ICCM, decoder always ready.
    lat = 1;
    instr_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("t1_req0", 32'(imem_req), 32'h1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick();
    @(negedge clk);
    chk("t1_addr1", imem_addr, 32'h4);
    tick();
    @(negedge clk);
    chk("t1_valid_c2", 32'(instr_valid), 32'h1);
    chk("t1_pc_c2", pc, 32'h0);
    chk("t1_instr_c2", instr, 32'hBEEF0000);
    tick();
    h0 = hs_cnt;
    repeat (10) tick();
    chk("t1_rate", 32'(hs_cnt - h0), 32'd10);

    // Decoder stalled: queue fills to DEPTH and the request stays low.
    instr_ready = 1'b0;
    do_reset();
    r0 = req_cnt;
    repeat (10) tick();
    chk("t2_req_count", 32'(req_cnt - r0), 32'd4);
    @(negedge clk);
    chk("t2_req_low", 32'(imem_req), 32'h0);
    chk("t2_pc_head", pc, 32'h0);
    tick();
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t2_req_low_pop", 32'(imem_req), 32'h0);
    tick();
    @(negedge clk);
    chk("t2_resume_req", 32'(imem_req), 32'h1);
    chk("t2_resume_addr", imem_addr, 32'h10);
    repeat (6) tick();

    // 3-cycle ICCM, redirect with three reads in flight.
    lat = 3;
    do_reset();
    tick();
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    c_red       = cyc;
    @(negedge clk);
    chk("t3_rvalid_at_redirect", 32'(imem_rvalid), 32'h1);
    tick();
    redirect = 1'b0;
    wait_valid("t3");
    chk("t3_latency", 32'(cyc - c_red), 32'd5);
    chk("t3_pc", pc, 32'h100);
    chk("t3_instr", instr, 32'hBFEF0100);

    // Redirect coinciding with rvalid and a handshake, unaligned target.
    lat = 1;
    do_reset();
    repeat (5) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    h0          = hs_cnt;
    @(negedge clk);
    chk("t4_valid_at_redirect", 32'(instr_valid), 32'h1);
    chk("t4_rvalid_at_redirect", 32'(imem_rvalid), 32'h1);
    tick();
    redirect = 1'b0;
    chk("t4_hs_counted", 32'(hs_cnt - h0), 32'd1);
    wait_valid("t4");
    chk("t4_pc", pc, 32'h200);
    chk("t4_instr", instr, 32'hBCEF0200);

    // Address wrap at the top of the address space.
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t5_addr_fff8", imem_addr, 32'hFFFF_FFF8);
    tick();
    @(negedge clk);
    chk("t5_addr_fffc", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("t5_addr_wrap", imem_addr, 32'h0);
    tick();
    @(negedge clk);
    chk("t5_valid", 32'(instr_valid), 32'h1);
    chk("t5_pc_fffc", pc, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a cycle.
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_arst_req", 32'(imem_req), 32'h0);
    chk("t5_arst_valid", 32'(instr_valid), 32'h0);
    chk("t5_arst_instr", instr, 32'h0);
    chk("t5_arst_pc", pc, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_refetch_addr", imem_addr, 32'h0);
    tick();
    wait_valid("t5");
    chk("t5_refetch_pc", pc, 32'h0);

`ifdef ATOMRV_IFU_PERF_EN
    // Seven handshakes followed by two redirects.
    tick();
    instr_ready = 1'b0;
    do_reset();
    chk("t6_perf_fetch_rst", perf_fetch, 32'h0);
    chk("t6_perf_flush_rst", perf_flush, 32'h0);
    repeat (6) tick();
    instr_ready = 1'b1;
    repeat (7) tick();
    instr_ready = 1'b0;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_perf_fetch", perf_fetch, 32'd7);
    chk("t6_perf_flush", perf_flush, 32'd2);
`endif

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
